aa_error_stats: RTL and testbench
=================================

AA_ERROR_STATS -- requirements
Module: aa_error_stats

Interface
REQ-001 Parameter N, default 16, operand/sum width of the upstream approximate adder.
REQ-002 Parameter NSAMP, default 1024, samples accepted per measurement run (range 1 to 2^32-1).
REQ-003 Parameter ACC_W, default 40, width of the error-distance accumulator.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  run request; sampled each edge.
REQ-007 in_valid  in  1  x/y/s/co carry a valid sample this cycle.
REQ-008 x, y  in  N each  operands that were applied to the approximate adder.
REQ-009 s  in  N  approximate sum from the adder.
REQ-010 co  in  1  approximate carry-out from the adder.
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 done  out  1  high while in DONE.
REQ-013 samp_cnt  out  32  samples accumulated in the current/last run.
REQ-014 err_cnt  out  32  samples with nonzero error distance.
REQ-015 ed_sum  out  ACC_W  sum of error distances.
REQ-016 ed_max  out  N+1  largest error distance seen.

Function
REQ-017 exact = x + y, zero-extended, N+1 bits; approx = {co,s}, N+1 bits; ed = |exact - approx|, N+1 bits, unsigned.
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; encoding free.
REQ-019 IDLE/DONE: start=1 -> RUN next edge; clear samp_cnt, err_cnt, ed_sum, ed_max to 0 on that same edge.
REQ-020 RUN: sample accepted on an edge where in_valid=1; start ignored.
REQ-021 Pipeline stage 1 registers ed and a valid bit on acceptance; stage 2 updates statistics one edge later; latency 2 edges from acceptance to visible outputs.
REQ-022 Accept counter reaches NSAMP -> RUN to DRAIN on that edge; no further acceptance in DRAIN, DONE or IDLE.
REQ-023 DRAIN -> DONE on the edge that retires the last stage-1 sample; done rises when samp_cnt = NSAMP.
REQ-024 Stage 2: samp_cnt += 1; err_cnt += 1 when ed != 0; ed_sum += ed; ed_max = ed when ed > ed_max.
REQ-025 ed_sum saturates at all-ones; no wrap-around.
REQ-026 DONE holds all statistics stable until the next start.
REQ-027 in_valid gaps in RUN stall acceptance only; no state change.
REQ-028 start and the final accept on the same edge: start ignored (state is RUN).

Reset
REQ-029 rst_n=0 immediately forces IDLE, busy=0, done=0, all statistics 0, pipeline valid 0, regardless of clock.
REQ-030 Reset mid-run discards the run; after release, the block stays in IDLE until start.

Verification
REQ-031 NSAMP=4; start; samples (x,y,s,co) = (0x0001,0x0001,0x0002,0), (0x00FF,0x00FF,0x01FF,0), (0xFFFF,0xFFFF,0xFFFF,1), (0x5555,0xAAAA,0xFFFF,0) back-to-back -> done=1, samp_cnt=4, err_cnt=2, ed_sum=2, ed_max=1.
REQ-032 NSAMP=2; sample x=0x8001,y=0x0101,s=0x8000,co=0 (exact 0x8102, ed=0x102) then exact sample -> ed_max=0x102, ed_sum=0x102, err_cnt=1; outputs update exactly 2 edges after each acceptance.
REQ-033 in_valid toggled 1,0,0,1 in RUN with NSAMP=2 -> samp_cnt=2, DONE only after second valid plus drain; in_valid during DONE leaves statistics unchanged.
REQ-034 ACC_W=4, NSAMP=3, three samples each ed=7 -> ed_sum=15 (saturated), samp_cnt=3.
REQ-035 rst_n pulled low after 2 of 4 samples -> all outputs 0 asynchronously, IDLE; new start then a full 4-sample run gives correct counts from 0.
REQ-036 start in DONE -> statistics cleared on that edge, busy=1 next cycle, done=0.

Source files
------------

// File: rtl/aa_error_stats.sv
// Error-distance statistics collector for an approximate adder. Each accepted
// sample is compared with the exact sum, and the results are accumulated over a run of NSAMP samples.
module aa_error_stats #(
  parameter int          N     = 16,
  parameter int unsigned NSAMP = 1024,
  parameter int          ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [N-1:0]     s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic [31:0]      samp_cnt,
  output logic [31:0]      err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N:0]       ed_max
);

  localparam int EW = N + 1;
  // The sum is one bit wider than the larger operand, so an overflow is
  // always visible before the sum saturates.
  localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;
  localparam logic [31:0]   NSAMP_U = 32'(NSAMP);
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc_cnt;
  logic        launch, accept, last_accept;
  logic [N:0]  exact, approx, ed;
  logic        s1_valid;
  logic [N:0]  s1_ed;
  logic [SW-1:0] sum_ext;

  assign launch      = start && (state == IDLE || state == DONE);
  assign accept      = (state == RUN) && in_valid;
  assign last_accept = accept && (acc_cnt == NSAMP_U - 32'd1);

  assign exact  = {1'b0, x} + {1'b0, y};
  assign approx = {co, s};
  assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);

  assign sum_ext = SW'(ed_sum) + SW'(s1_ed);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment at the top keeps every path assigned, so
  // no latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last_accept) state_nxt = DRAIN;
      // Stage 1 holds exactly the final sample here, and that sample
      // retires on this edge.
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs from the state machine
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Accept counter and pipeline stage 1
  // NOTE: every register is reset asynchronously, including the pipeline,
  // so a reset in the middle of a run leaves no sample in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_ed    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_ed <= ed;
      if (launch)      acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 32'd1;
    end
  end

  // Stage 2: statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      err_cnt  <= '0;
      ed_sum   <= '0;
      ed_max   <= '0;
    end else if (launch) begin
      samp_cnt <= '0;
      err_cnt  <= '0;
      ed_sum   <= '0;
      ed_max   <= '0;
    end else if (s1_valid) begin
      samp_cnt <= samp_cnt + 32'd1;
      if (s1_ed != '0)     err_cnt <= err_cnt + 32'd1;
      if (sum_ext > ACC_MAX) ed_sum <= '1;
      else                   ed_sum <= sum_ext[ACC_W-1:0];
      if (s1_ed > ed_max)  ed_max <= s1_ed;
    end
  end

endmodule

// File: tb/tb_aa_error_stats.sv
// Directed bench for aa_error_stats with three instances: NSAMP=4, NSAMP=2,
// and a narrow accumulator (ACC_W=4, NSAMP=3) that exercises saturation.
module tb_aa_error_stats;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        co;
    logic [16:0] ed;
  } samp_t;

  typedef struct {
    logic        vld;
    logic [31:0] e_samp;
    logic        e_busy;
    logic        e_done;
  } tog_t;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, co = 1'b0;
  logic        start4 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [15:0] x = '0, y = '0, s = '0;

  logic        busy4, done4, busy2, done2, busy3, done3;
  logic [31:0] samp_cnt4, err_cnt4, samp_cnt2, err_cnt2, samp_cnt3, err_cnt3;
  logic [39:0] ed_sum4, ed_sum2;
  logic [3:0]  ed_sum3;
  logic [16:0] ed_max4, ed_max2, ed_max3;

  int n_checks = 0;
  int n_fail   = 0;

  samp_t tbl[4];
  tog_t  tog[5];
  samp_t idle_s, err3_s, exact_s, big_s, seven_s;

  aa_error_stats #(.N(16), .NSAMP(4), .ACC_W(40)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid),
    .x(x), .y(y), .s(s), .co(co), .busy(busy4), .done(done4),
    .samp_cnt(samp_cnt4), .err_cnt(err_cnt4), .ed_sum(ed_sum4), .ed_max(ed_max4));

  aa_error_stats #(.N(16), .NSAMP(2), .ACC_W(40)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
    .x(x), .y(y), .s(s), .co(co), .busy(busy2), .done(done2),
    .samp_cnt(samp_cnt2), .err_cnt(err_cnt2), .ed_sum(ed_sum2), .ed_max(ed_max2));

  aa_error_stats #(.N(16), .NSAMP(3), .ACC_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid),
    .x(x), .y(y), .s(s), .co(co), .busy(busy3), .done(done3),
    .samp_cnt(samp_cnt3), .err_cnt(err_cnt3), .ed_sum(ed_sum3), .ed_max(ed_max3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input samp_t v, input logic vld);
    x = v.x; y = v.y; s = v.s; co = v.co; in_valid = vld;
  endtask

  task automatic check4(input string tag, input logic [31:0] e_samp, input logic [31:0] e_err,
                        input logic [63:0] e_sum, input logic [63:0] e_max,
                        input logic e_busy, input logic e_done);
    check({tag, " samp_cnt"}, 64'(samp_cnt4), 64'(e_samp));
    check({tag, " err_cnt"},  64'(err_cnt4),  64'(e_err));
    check({tag, " ed_sum"},   64'(ed_sum4),   e_sum);
    check({tag, " ed_max"},   64'(ed_max4),   e_max);
    check({tag, " busy"},     64'(busy4),     64'(e_busy));
    check({tag, " done"},     64'(done4),     64'(e_done));
  endtask

  // Full 4-sample run on u4; start is held high through RUN to show it is ignored.
  task automatic run_table4(input string tag);
    logic [31:0] e_samp, e_err;
    logic [63:0] e_sum, e_max;
    e_samp = 0; e_err = 0; e_sum = 0; e_max = 0;
    drive(idle_s, 1'b0);
    start4 = 1'b1;
    step();
    check4({tag, " launch"}, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(tbl[i], 1'b1);
      else       drive(idle_s, 1'b0);
      start4 = (i < 4);
      step();
      if (i >= 1 && i <= 4) begin
        e_samp++;
        if (tbl[i-1].ed != 0) e_err++;
        e_sum += 64'(tbl[i-1].ed);
        if (64'(tbl[i-1].ed) > e_max) e_max = 64'(tbl[i-1].ed);
      end
      check4($sformatf("%s[%0d]", tag, i), e_samp, e_err, e_sum, e_max, (i < 4), (i >= 4));
    end
    start4 = 1'b0;
    check4({tag, " final"}, 4, 2, 2, 1, 1'b0, 1'b1);
  endtask

  initial begin
    tbl[0] = '{16'h0001, 16'h0001, 16'h0002, 1'b0, 17'h0};
    tbl[1] = '{16'h00FF, 16'h00FF, 16'h01FF, 1'b0, 17'h1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1};
    tbl[3] = '{16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 17'h0};
    idle_s  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 17'h0};
    err3_s  = '{16'h0001, 16'h0001, 16'h0005, 1'b0, 17'h3};
    exact_s = '{16'h0002, 16'h0003, 16'h0005, 1'b0, 17'h0};
    big_s   = '{16'h8001, 16'h0101, 16'h8000, 1'b0, 17'h102};
    seven_s = '{16'h0000, 16'h0000, 16'h0007, 1'b0, 17'h7};
    tog[0] = '{1'b1, 32'd0, 1'b1, 1'b0};
    tog[1] = '{1'b0, 32'd1, 1'b1, 1'b0};
    tog[2] = '{1'b0, 32'd1, 1'b1, 1'b0};
    tog[3] = '{1'b1, 32'd1, 1'b1, 1'b0};
    tog[4] = '{1'b0, 32'd2, 1'b0, 1'b1};

    // Reset state
    #3;
    check4("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    step();
    check4("idle", 0, 0, 0, 0, 1'b0, 1'b0);

    // Basic 4-sample run, then DONE must ignore in_valid
    run_table4("run4a");
    for (int i = 0; i < 3; i++) begin
      drive(big_s, 1'b1);
      step();
      check4($sformatf("done_hold[%0d]", i), 4, 2, 2, 1, 1'b0, 1'b1);
    end

    // start in DONE clears the statistics on the same edge
    drive(idle_s, 1'b0);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check4("restart", 0, 0, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset after two samples
    drive(tbl[1], 1'b1); step();
    drive(tbl[2], 1'b1); step();
    drive(idle_s, 1'b0); step();
    check4("partial", 2, 2, 2, 1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check4("async_rst", 0, 0, 0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    drive(big_s, 1'b1);
    step(); step();
    check4("post_rst_idle", 0, 0, 0, 0, 1'b0, 1'b0);
    run_table4("run4b");

    // Two-edge latency, NSAMP=2
    drive(idle_s, 1'b0);
    start2 = 1'b1; step(); start2 = 1'b0;
    drive(big_s, 1'b1); step();
    check("lat edge1 ed_max", 64'(ed_max2), 64'h0);
    check("lat edge1 samp_cnt", 64'(samp_cnt2), 64'd0);
    drive(exact_s, 1'b1); step();
    check("lat edge2 ed_max", 64'(ed_max2), 64'h102);
    check("lat edge2 ed_sum", 64'(ed_sum2), 64'h102);
    check("lat edge2 err_cnt", 64'(err_cnt2), 64'd1);
    check("lat edge2 busy", 64'(busy2), 64'd1);
    drive(idle_s, 1'b0); step();
    check("lat final samp_cnt", 64'(samp_cnt2), 64'd2);
    check("lat final err_cnt", 64'(err_cnt2), 64'd1);
    check("lat final ed_sum", 64'(ed_sum2), 64'h102);
    check("lat final ed_max", 64'(ed_max2), 64'h102);
    check("lat final done", 64'(done2), 64'd1);

    // in_valid gaps during RUN, NSAMP=2
    start2 = 1'b1; step(); start2 = 1'b0;
    check("gap launch samp_cnt", 64'(samp_cnt2), 64'd0);
    check("gap launch ed_max", 64'(ed_max2), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (tog[i].vld) drive((i == 0) ? err3_s : exact_s, 1'b1);
      else            drive(idle_s, 1'b0);
      step();
      check($sformatf("gap[%0d] samp_cnt", i), 64'(samp_cnt2), 64'(tog[i].e_samp));
      check($sformatf("gap[%0d] busy", i), 64'(busy2), 64'(tog[i].e_busy));
      check($sformatf("gap[%0d] done", i), 64'(done2), 64'(tog[i].e_done));
    end
    check("gap ed_sum", 64'(ed_sum2), 64'd3);
    check("gap err_cnt", 64'(err_cnt2), 64'd1);
    check("gap ed_max", 64'(ed_max2), 64'd3);
    drive(big_s, 1'b1); step(); step();
    check("gap hold samp_cnt", 64'(samp_cnt2), 64'd2);
    check("gap hold ed_sum", 64'(ed_sum2), 64'd3);

    // Saturating accumulator, ACC_W=4, NSAMP=3
    drive(idle_s, 1'b0);
    start3 = 1'b1; step(); start3 = 1'b0;
    drive(seven_s, 1'b1); step();
    check("sat e0 ed_sum", 64'(ed_sum3), 64'd0);
    step();
    check("sat e1 ed_sum", 64'(ed_sum3), 64'd7);
    step();
    check("sat e2 ed_sum", 64'(ed_sum3), 64'd14);
    drive(idle_s, 1'b0); step();
    check("sat e3 ed_sum", 64'(ed_sum3), 64'd15);
    check("sat samp_cnt", 64'(samp_cnt3), 64'd3);
    check("sat err_cnt", 64'(err_cnt3), 64'd3);
    check("sat ed_max", 64'(ed_max3), 64'd7);
    check("sat done", 64'(done3), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
